mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit for the EX stage; successor to the fixed 32-bit divider behind div_readyE/div_stallE.
- Executes signed and unsigned MULT and DIV over a shared radix-2 shift/add-subtract datapath.
- Returns a {hi,lo} result for the HILO write and drives the pipeline stall combinationally.
- Supports cancel on a committed exception, which the old divider did not.

---
 rtl/mdu_iter.sv | 160 ++++++++++++++++
 tb/tb_mdu_iter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit: signed/unsigned MULT and DIV over a shared
// shift/add-subtract datapath, WIDTH cycles per op, {hi,lo} result with pipeline stall.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cancel,
  output logic                 stall,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dz_q, dz_d;

  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     rem_sh, diff, sum;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign accept = (state_q == S_IDLE) && start && !cancel;
  assign a_neg  = !op[0] && a[WIDTH-1];
  assign b_neg  = !op[0] && b[WIDTH-1];
  assign abs_a  = a_neg ? -a : a;
  assign abs_b  = b_neg ? -b : b;

  // Restoring divide step: remainder shifted left with the next dividend bit.
  assign rem_sh = {acc_q, lo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, opnd_q};
  // Multiply step: add multiplicand into the high half when the multiplier LSB is set.
  assign sum    = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};

  assign prod   = {acc_q, lo_q};
  assign prod_s = neg_res_q ? -prod : prod;
  // Divide by zero naturally leaves |a| in the remainder, so the sign fix restores raw a.
  assign quo_s  = bzero_q ? '1 : (neg_res_q ? -lo_q : lo_q);
  assign rem_s  = neg_rem_q ? -acc_q : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_SIGN;
      S_SIGN:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cancel) state_d = S_IDLE;
  end

  always_comb begin
    stall = accept || (state_q == S_CALC) || (state_q == S_SIGN);
    if (cancel) stall = 1'b0;
    ready = (state_q == S_DONE);
  end

  always_comb begin
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    result_d  = result_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_div_d  = op[1];
          opnd_d    = op[1] ? abs_b : abs_a;
          lo_d      = op[1] ? abs_a : abs_b;
          acc_d     = '0;
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          bzero_d   = op[1] && (b == '0);
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          if (!diff[WIDTH]) begin
            acc_d = diff[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_sh[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = sum[WIDTH:1];
          lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        end
      end
      S_SIGN: begin
        if (!cancel) begin
          result_d = is_div_q ? {rem_s, quo_s} : prod_s;
          dz_d     = is_div_q && bzero_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      dz_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      dz_q      <= dz_d;
    end
  end

  assign result   = result_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: 32-bit ops, cancel/start interplay,
// async reset mid-operation, and one 8-bit divide.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, cancel;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        stall, ready, div_zero;
  logic [63:0] result;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        stall8, ready8, div_zero8;
  logic [15:0] result8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .stall(stall), .ready(ready), .result(result), .div_zero(div_zero)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .cancel(1'b0),
    .stall(stall8), .ready(ready8), .result(result8), .div_zero(div_zero8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op in the current cycle (cycle 0) and follows it to completion.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [63:0] er, input logic edz,
                        input bit noise);
    int n;
    bit stall_ok, got;
    start = 1'b1; op = o; a = va; b = vb; cancel = 1'b0;
    @(negedge clk);
    stall_ok = (stall === 1'b1) && (ready === 1'b0);
    @(posedge clk); #1;
    start = 1'b0; a = ~va; b = ~vb;
    got = 0; n = 0;
    for (int k = 1; k <= 60 && !got; k++) begin
      if (noise && k == 5) begin start = 1'b1; op = 2'b01; a = 32'h5; b = 32'h7; end
      if (noise && k == 6) start = 1'b0;
      @(negedge clk);
      if (ready === 1'b1) begin
        got = 1; n = k;
      end else begin
        if (stall !== 1'b1) stall_ok = 0;
        @(posedge clk); #1;
      end
    end
    chk({tag, "/latency"}, 64'(n), 64'd34);
    chk({tag, "/stall_busy"}, 64'(stall_ok), 64'd1);
    chk({tag, "/stall_done"}, 64'(stall), 64'd0);
    chk({tag, "/result"}, result, er);
    chk({tag, "/div_zero"}, 64'(div_zero), 64'(edz));
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "/ready_pulse"}, 64'(ready), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bit ok, got;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    #2;
    chk("reset/stall", 64'(stall), 64'd0);
    chk("reset/ready", 64'(ready), 64'd0);
    chk("reset/result", result, 64'd0);
    chk("reset/div_zero", 64'(div_zero), 64'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    run_op("div_m7_2",   2'b10, 32'hFFFFFFF9, 32'h2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 0);
    run_op("divu_big",   2'b11, 32'hFFFFFFFF, 32'h10,       64'h0000000F_0FFFFFFF, 1'b0, 0);
    run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 0);
    run_op("mult_m2_3",  2'b00, 32'hFFFFFFFE, 32'h3,        64'hFFFFFFFF_FFFFFFFA, 1'b0, 0);
    run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 0);
    run_op("divu_zero",  2'b11, 32'h1234,     32'h0,        64'h00001234_FFFFFFFF, 1'b1, 0);
    run_op("mult_after", 2'b00, 32'h7,        32'hFFFFFFFB, 64'hFFFFFFFF_FFFFFFDD, 1'b0, 0);
    run_op("div_7_m2",   2'b10, 32'h7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 0);
    run_op("div_m5_0",   2'b10, 32'hFFFFFFFB, 32'h0,        64'hFFFFFFFB_FFFFFFFF, 1'b1, 0);

    // Cancel a MULT in cycle 10, refuse start+cancel in cycle 11, issue DIV in cycle 12.
    start = 1'b1; op = 2'b00; a = 32'h3; b = 32'h4;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (stall !== 1'b1 || ready !== 1'b0) ok = 0;
      @(posedge clk); #1;
    end
    chk("cancel/busy_before", 64'(ok), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel/stall_c10", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00;
    @(negedge clk);
    chk("cancel/stall_c11", 64'(stall), 64'd0);
    chk("cancel/ready_c11", 64'(ready), 64'd0);
    chk("cancel/result_kept", result, 64'hFFFFFFFB_FFFFFFFF);
    chk("cancel/dz_kept", 64'(div_zero), 64'd1);
    @(posedge clk); #1;
    run_op("div_after_cancel", 2'b10, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 1);

    // Async reset between edges while in CALC.
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst/stall_before", 64'(stall), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst/stall", 64'(stall), 64'd0);
    chk("rst/ready", 64'(ready), 64'd0);
    chk("rst/result", result, 64'd0);
    chk("rst/div_zero", 64'(div_zero), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // WIDTH=8 signed divide: -127 / 3.
    start8 = 1'b1; op8 = 2'b10; a8 = 8'h81; b8 = 8'h03;
    @(negedge clk);
    @(posedge clk); #1;
    start8 = 1'b0;
    got = 0; n = 0;
    for (int k = 1; k <= 30 && !got; k++) begin
      @(negedge clk);
      if (ready8 === 1'b1) begin got = 1; n = k; end
      else begin @(posedge clk); #1; end
    end
    chk("w8/latency", 64'(n), 64'd10);
    chk("w8/result", 64'(result8), 64'h0000_0000_0000_FFD6);
    chk("w8/div_zero", 64'(div_zero8), 64'd0);
    chk("w8/stall_done", 64'(stall8), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
